// File: rtl/dmem_pkg.sv
// dmem_pkg: address map, status bit positions and default sizes for dmem_responder
package dmem_pkg;
    localparam logic [31:0] RAM_BASE      = 32'h0000_0000;
    localparam logic [31:0] RAM_LIMIT     = 32'h0000_0FFF;
    localparam logic [31:0] GPIO_ADDR     = 32'h8000_0000;
    localparam logic [31:0] CYCLE_LO_ADDR = 32'h8000_0004;
    localparam logic [31:0] CYCLE_HI_ADDR = 32'h8000_0008;
    localparam logic [31:0] DBG_ADDR      = 32'h8000_000C;
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int DEF_RAM_WORDS = 1024;
    localparam int DEF_DBG_DEPTH = 8;
endpackage

// File: rtl/dbg_fifo.sv
// dbg_fifo: byte FIFO for the debug port; drops pushes while full and latches a sticky overflow
module dbg_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEF_DBG_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full,
    output logic       overflow
);
    localparam int PW = $clog2(DEPTH);
    logic [7:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0] count;
    logic do_push, do_pop;
    // full is the pre-edge state, so a push on a full FIFO drops even with a concurrent pop
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = count == '0;
    assign full    = count == (PW+1)'(DEPTH);
    assign head    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
            if (push && full) overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: zero-wait data-memory responder with RAM, GPIO, 64-bit cycle counter and debug FIFO
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS = DEF_RAM_WORDS,
    parameter int DBG_DEPTH = DEF_DBG_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic [31:0] gpio_out,
    output logic [7:0]  dbg_data,
    output logic        dbg_valid,
    input  logic        dbg_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    logic [31:0] ram [RAM_WORDS];
    logic [31:0] word, status;
    logic [AW-1:0] ram_idx;
    logic [63:0] cycle_cnt;
    logic ram_hit, gpio_hit, lo_hit, hi_hit, dbg_hit, wr_en;
    logic fifo_empty, fifo_full, fifo_ovf;
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^daddr[1:0];
    assign word     = {2'b00, daddr[31:2]};
    assign ram_idx  = daddr[AW+1:2];
    assign ram_hit  = word <= {2'b00, RAM_LIMIT[31:2]} && word < 32'(RAM_WORDS);
    assign gpio_hit = daddr[31:2] == GPIO_ADDR[31:2];
    assign lo_hit   = daddr[31:2] == CYCLE_LO_ADDR[31:2];
    assign hi_hit   = daddr[31:2] == CYCLE_HI_ADDR[31:2];
    assign dbg_hit  = daddr[31:2] == DBG_ADDR[31:2];
    assign wr_en    = !reset && dwe != 4'b0;
    assign dbg_valid = !fifo_empty;
    always_comb begin
        status = '0;
        status[ST_EMPTY] = fifo_empty;
        status[ST_FULL]  = fifo_full;
        status[ST_OVF]   = fifo_ovf;
        drdata = ram_hit ? ram[ram_idx] :
                 gpio_hit ? gpio_out :
                 lo_hit ? cycle_cnt[31:0] :
                 hi_hit ? cycle_cnt[63:32] :
                 dbg_hit ? status : '0;
    end
    // RAM deliberately has no reset so contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (wr_en && ram_hit)
            for (int i = 0; i < 4; i++)
                if (dwe[i]) ram[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (reset) gpio_out <= '0;
        else if (wr_en && gpio_hit)
            for (int i = 0; i < 4; i++)
                if (dwe[i]) gpio_out[8*i +: 8] <= dwdata[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        cycle_cnt <= reset ? '0 : cycle_cnt + 64'd1;
    end
    dbg_fifo #(.DEPTH(DBG_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (!reset && dbg_hit && dwe[0]),
        .push_data (dwdata[7:0]),
        .pop       (dbg_valid && dbg_ready),
        .head      (dbg_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .overflow  (fifo_ovf)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random stimulus against a queue/array reference model
module tb_dmem_responder;
    import dmem_pkg::*;
    localparam int DEPTH = 8;
    logic clk = 1'b0, reset = 1'b1, dbg_ready = 1'b0;
    logic [31:0] daddr = GPIO_ADDR, dwdata = '0;
    logic [3:0] dwe = '0;
    logic [31:0] drdata, gpio_out;
    logic [7:0] dbg_data;
    logic dbg_valid;
    int vectors = 0, miscompares = 0;
    logic [31:0] mram [1024];
    logic [31:0] mgpio = '0;
    logic [63:0] mcyc = '0;
    logic [7:0] mq [$];
    logic movf = 1'b0;

    dmem_responder dut (
        .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
        .drdata(drdata), .gpio_out(gpio_out), .dbg_data(dbg_data),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] we);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] addr);
        logic [31:0] a = {addr[31:2], 2'b00};
        if (a <= RAM_LIMIT) return mram[a[11:2]];
        case (a)
            GPIO_ADDR:     return mgpio;
            CYCLE_LO_ADDR: return mcyc[31:0];
            CYCLE_HI_ADDR: return mcyc[63:32];
            DBG_ADDR:      return {29'b0, movf, mq.size() == DEPTH, mq.size() == 0};
            default:       return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic [31:0] a = {daddr[31:2], 2'b00};
        logic was_full = mq.size() == DEPTH;
        if (reset) begin
            mcyc = '0;
            mgpio = '0;
            mq.delete();
            movf = 1'b0;
        end else begin
            mcyc++;
            if (dwe != 4'b0 && a <= RAM_LIMIT) mram[a[11:2]] = merge(mram[a[11:2]], dwdata, dwe);
            if (a == GPIO_ADDR) mgpio = merge(mgpio, dwdata, dwe);
            if (mq.size() > 0 && dbg_ready) void'(mq.pop_front());
            if (a == DBG_ADDR && dwe[0]) begin
                if (was_full) movf = 1'b1;
                else mq.push_back(dwdata[7:0]);
            end
        end
    endtask

    task automatic check_all();
        check("drdata", drdata, exp_rd(daddr));
        check("gpio_out", gpio_out, mgpio);
        check("dbg_valid", 32'(dbg_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check("dbg_data", 32'(dbg_data), 32'(mq[0]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        daddr = a; dwdata = d; dwe = we;
        tick();
        dwe = '0;
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        daddr = a;
        #1 check(tag, drdata, exp);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0, 1:    a = 32'($urandom_range(0, 1) != 0 ? $urandom_range(0, 15) : $urandom_range(1020, 1023)) << 2;
            2:       a = GPIO_ADDR;
            3:       a = CYCLE_LO_ADDR;
            4:       a = CYCLE_HI_ADDR;
            5, 6:    a = DBG_ADDR;
            default: a = $urandom_range(0, 1) != 0 ? 32'h0000_1000 + 32'($urandom_range(0, 255) << 2) : 32'h8000_0010;
        endcase
        return a | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        peek("cyc_first", CYCLE_LO_ADDR, 32'd0);
        tick();
        check("cyc_second", drdata, 32'd1);
        repeat (4) tick();
        check("cyc_fifth", drdata, 32'd5);

        for (int i = 0; i < 16; i++) wr(32'(i) << 2, $urandom, 4'hF);
        for (int i = 1020; i < 1024; i++) wr(32'(i) << 2, $urandom, 4'hF);

        wr(32'h10, 32'h1122_3344, 4'hF);
        wr(32'h12, 32'hAAAA_AAAA, 4'b0100);
        peek("byte_lane", 32'h10, 32'h11AA_3344);
        wr(32'h10, 32'h5555_5555, 4'b0000);
        peek("dwe_zero", 32'h10, 32'h11AA_3344);
        wr(CYCLE_LO_ADDR, 32'h1234_5678, 4'hF);
        wr(32'h8000_0010, 32'h1234_5678, 4'hF);
        peek("unmapped_rd", 32'h8000_0010, 32'h0);

        daddr = CYCLE_LO_ADDR;
        force dut.cycle_cnt = {mcyc[63:32], 32'hFFFF_FFFF};
        mcyc = {mcyc[63:32], 32'hFFFF_FFFF};
        #1 release dut.cycle_cnt;
        check("cyc_preload", drdata, 32'hFFFF_FFFF);
        tick();
        check("cyc_lo_wrap", drdata, 32'h0);
        peek("cyc_hi_inc", CYCLE_HI_ADDR, 32'h1);

        dbg_ready = 1'b0;
        for (int i = 1; i <= 9; i++) wr(DBG_ADDR, {4{8'(i)}}, 4'b0001);
        peek("fifo_full_status", DBG_ADDR, 32'b110);
        dbg_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("fifo_pop_seq", 32'(dbg_data), 32'(i));
            tick();
        end
        check("fifo_empty_status", drdata, 32'b101);
        wr(DBG_ADDR, 32'h6666_6666, 4'b1110);
        check("dbg_lane0_only", 32'(dbg_valid), 32'd0);

        dbg_ready = 1'b0;
        wr(DBG_ADDR, 32'h5A5A_5A5A, 4'b0001);
        tick();
        check("bp_hold", 32'(dbg_data), 32'h5A);
        dbg_ready = 1'b1;
        tick();
        check("bp_one_pop", 32'(dbg_valid), 32'd0);
        dbg_ready = 1'b0;
        tick();
        dbg_ready = 1'b1;
        tick();

        reset = 1'b1; tick(); reset = 1'b0;
        dbg_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(DBG_ADDR, {4{8'(8'h30 + i)}}, 4'b0001);
        dbg_ready = 1'b1;
        wr(DBG_ADDR, 32'h7777_7777, 4'b0001);
        dbg_ready = 1'b0;
        peek("simul_full", DBG_ADDR, 32'b100);
        dbg_ready = 1'b1;
        repeat (8) tick();
        dbg_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(DBG_ADDR, {4{8'(8'h40 + i)}}, 4'b0001);
        dbg_ready = 1'b1;
        wr(DBG_ADDR, 32'h4545_4545, 4'b0001);
        repeat (3) tick();
        check("half_order_last", 32'(dbg_data), 32'h45);
        tick();
        check("half_drained", 32'(dbg_valid), 32'd0);

        dbg_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(DBG_ADDR, {4{8'(8'hC0 + i)}}, 4'b0001);
        wr(GPIO_ADDR, 32'hDEAD_BEEF, 4'hF);
        check("gpio_set", gpio_out, 32'hDEAD_BEEF);
        reset = 1'b1;
        wr(32'h10, 32'hFFFF_FFFF, 4'hF);
        reset = 1'b0;
        check("rst_valid", 32'(dbg_valid), 32'd0);
        check("rst_gpio", gpio_out, 32'h0);
        peek("rst_status", DBG_ADDR, 32'b001);
        peek("rst_ram_kept", 32'h10, 32'h11AA_3344);

        for (int n = 0; n < 800; n++) begin
            reset = $urandom_range(0, 63) == 0;
            daddr = rand_addr();
            dwdata = $urandom;
            dwe = $urandom_range(0, 1) != 0 ? 4'($urandom) : 4'b0;
            dbg_ready = $urandom_range(0, 2) != 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have the following ports: clk  input  1  clock; all state updates on rising edge.
REQ-002 The block SHALL have the following port: reset  input  1  synchronous, active-high.
REQ-003 The block SHALL have the following port: daddr  input  32  byte address from the CPU data port.
REQ-004 The block SHALL have the following port: dwdata  input  32  write data, already lane-replicated by the CPU.
REQ-005 The block SHALL have the following port: dwe  input  4  byte-lane write enables; bit n selects dwdata[8n+7:8n].
REQ-006 The block SHALL have the following port: drdata  output  32  read data, full aligned word.
REQ-007 The block SHALL have the following port: gpio_out  output  32  GPIO register value.
REQ-008 The block SHALL have the following port: dbg_data  output  8  debug byte at FIFO head.
REQ-009 The block SHALL have the following port: dbg_valid  output  1  FIFO non-empty.
REQ-010 The block SHALL have the following port: dbg_ready  input  1  consumer accepts dbg_data.
REQ-011 The block SHALL use the following parameters: RAM_WORDS (default 1024, RAM size in words) and DBG_DEPTH (default 8, FIFO entries, power of two).

Function
REQ-012 The block SHALL decode addresses on daddr[31:2] only, ignoring daddr[1:0], using this map:
- RAM: 0x0000_0000..0x0000_0FFF, word index daddr[11:2]
- GPIO: 0x8000_0000, R/W
- CYCLE_LO: 0x8000_0004, RO
- CYCLE_HI: 0x8000_0008, RO
- DBG: 0x8000_000C; writes push, reads return status
REQ-013 drdata SHALL be combinational from daddr in the same cycle, giving zero-wait-state reads for a single-cycle CPU.
REQ-014 A RAM read SHALL return the stored word.
REQ-015 A read of any unmapped address SHALL return 32'h0.
REQ-016 On a clk edge with dwe!=0 and daddr in RAM, the block SHALL update only the lanes whose dwe bit is set; other lanes SHALL keep their values.
REQ-017 A GPIO write SHALL update per lane, with the same lane rules as RAM.
REQ-018 gpio_out SHALL be the GPIO register value.
REQ-019 dwe==0 SHALL modify no state.
REQ-020 Writes to CYCLE_LO, CYCLE_HI and unmapped addresses SHALL be ignored.
REQ-021 The block SHALL keep a 64-bit cycle counter that increments by 1 every cycle reset is low and wraps 2^64-1 -> 0.
REQ-022 CYCLE_LO SHALL read counter[31:0].
REQ-023 CYCLE_HI SHALL read counter[63:32].
REQ-024 A DBG write with dwe[0]=1 SHALL push dwdata[7:0] into the FIFO if it is not full at that edge.
REQ-025 A DBG write with dwe[0]=0 SHALL be ignored.
REQ-026 A push while full SHALL be dropped and SHALL set a sticky overflow flag.
REQ-027 A DBG read SHALL return {29'b0, overflow, full, empty}.
REQ-028 FIFO pop SHALL occur on a clk edge where dbg_valid && dbg_ready.
REQ-029 dbg_data SHALL equal the head entry whenever dbg_valid=1.
REQ-030 dbg_data and the head entry SHALL be stable while dbg_valid=1 and dbg_ready=0.
REQ-031 For a simultaneous push and pop, "full" SHALL be evaluated before the pop, so a push on a full FIFO is dropped even if a pop occurs on the same edge.
REQ-032 For a simultaneous push and pop on a non-full, non-empty FIFO, both SHALL occur and the count SHALL be unchanged.
REQ-033 A push into an empty FIFO SHALL raise dbg_valid on the following cycle, giving one cycle of latency.
REQ-034 The read and write pointers SHALL wrap modulo DBG_DEPTH.
REQ-035 The occupancy count SHALL be log2(DBG_DEPTH)+1 bits wide.

Reset
REQ-036 While reset=1 at a clk edge, the block SHALL clear the counter to 0, gpio_out to 0, the FIFO pointers and count to 0 (empty), and overflow to 0.
REQ-037 While reset=1, dbg_valid SHALL be 0 in the cycle after that edge.
REQ-038 While reset=1, writes SHALL be ignored in the same cycle.
REQ-039 RAM contents SHALL NOT be cleared by reset.
REQ-040 Reset asserted mid-transfer SHALL discard all queued debug bytes.
REQ-041 The first counter value read after reset deasserts SHALL be 0, followed by 1, 2, ...

Structure
REQ-042 A shared package dmem_pkg SHALL hold the address-map constants (RAM base/limit, GPIO, CYCLE_LO, CYCLE_HI, DBG), the status bit positions, and the default parameter values.
REQ-043 The FIFO SHALL be a sub-module dbg_fifo (parameter DEPTH; ports push, push_data, pop, head, empty, full, overflow).
REQ-044 Address decode, the RAM array, GPIO and the counter SHALL reside in dmem_responder.

Verification
REQ-045 Byte lanes: SW 0x11223344 to 0x10, then dwe=0100 with dwdata=0xAAAAAAAA to 0x12 -> read 0x10 returns 0x11AA3344.
REQ-046 Counter: deassert reset, read CYCLE_LO on cycles 0, 1, 5 -> 0, 1, 5; preload near wrap by forcing counter[31:0]=0xFFFFFFFF -> next cycle LO=0 and HI increments by 1.
REQ-047 FIFO fill/overflow: 9 pushes 0x01..0x09 with dbg_ready=0 -> status=0b110 (full), byte 0x09 dropped; dbg_ready=1 -> dbg_data sequence 0x01..0x08, then status=0b101.
REQ-048 Backpressure: push 0x5A, toggle dbg_ready 0/1 every cycle -> dbg_data holds 0x5A until the ready cycle, one pop only.
REQ-049 Simultaneous push/pop on full with dbg_ready=1 -> count drops by 1 and the push is dropped with overflow set; on half-full -> count unchanged and order preserved.
REQ-050 Reset mid-operation: 4 bytes queued and GPIO=0xDEADBEEF, assert reset 1 cycle -> dbg_valid=0, gpio_out=0, status=0b001, and a previously written RAM word is unchanged.
